// File: rtl/udl_counter_pkg.sv
// Shared constants and operation encoding for the up/down/load counter.
// The decode function fixes the edge priority in one place.
package udl_counter_pkg;

    localparam int UDL_DEFAULT_BITS = 4;

    typedef enum logic [2:0] {
        OP_HOLD  = 3'd0,
        OP_LOAD  = 3'd1,
        OP_INC   = 3'd2,
        OP_DEC   = 3'd3,
        OP_CLEAR = 3'd4
    } udl_op_e;

    // Priority, highest first: clear, load, count (direction from up), hold.
    function automatic udl_op_e udl_decode_op(
        input logic reset_n,
        input logic load,
        input logic enable,
        input logic up
    );
        udl_op_e op;
        if (!reset_n) begin
            op = OP_CLEAR;
        end else if (load) begin
            op = OP_LOAD;
        end else if (enable) begin
            op = up ? OP_INC : OP_DEC;
        end else begin
            op = OP_HOLD;
        end
        return op;
    endfunction

endpackage

// File: rtl/udl_counter_tick.sv
// Terminal-count flags: high on the cycle whose next edge wraps the count.
module udl_counter_tick #(
    parameter int bits = 4
) (
    input  logic [bits-1:0] i_q,
    input  logic            i_up,
    input  logic            i_enable,
    input  logic            i_load,
    output logic            o_max_tick,
    output logic            o_min_tick
);

    logic w_count_s;

    assign w_count_s  = i_enable & ~i_load;
    assign o_max_tick = (&i_q) & i_up & w_count_s;
    assign o_min_tick = ~(|i_q) & ~i_up & w_count_s;

endmodule

// File: rtl/udl_counter.sv
// Parameterized synchronous up/down counter with parallel load and enable.
// Modulo-2^bits arithmetic; tick flags flag the wrapping edge in advance.
module udl_counter
    import udl_counter_pkg::*;
#(
    parameter int bits = UDL_DEFAULT_BITS
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            enable,
    input  logic            up,
    input  logic            load,
    input  logic [bits-1:0] D,
    output logic [bits-1:0] Q,
    output logic            max_tick,
    output logic            min_tick
);

    localparam logic [bits-1:0] ONE = bits'(1);

    udl_op_e         w_op;
    logic [bits-1:0] w_q_next;
    logic [bits-1:0] r_q;

    // Next-state selection from the priority-encoded operation.
    always_comb begin
        w_op     = udl_decode_op(reset_n, load, enable, up);
        w_q_next = r_q;
        case (w_op)
            OP_CLEAR: w_q_next = '0;
            OP_LOAD:  w_q_next = D;
            OP_INC:   w_q_next = r_q + ONE;
            OP_DEC:   w_q_next = r_q - ONE;
            OP_HOLD:  w_q_next = r_q;
            default:  w_q_next = r_q;
        endcase
    end

    // Count register with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_q <= '0;
        end else begin
            r_q <= w_q_next;
        end
    end

    assign Q = r_q;

    udl_counter_tick #(
        .bits(bits)
    ) u_tick (
        .i_q       (r_q),
        .i_up      (up),
        .i_enable  (enable),
        .i_load    (load),
        .o_max_tick(max_tick),
        .o_min_tick(min_tick)
    );

endmodule

// File: tb/tb_udl_counter.sv
// Directed scoreboard bench for udl_counter at the default 4-bit width.
module tb_udl_counter;

    logic       clk;
    logic       reset_n;
    logic       enable;
    logic       up;
    logic       load;
    logic [3:0] D;
    logic [3:0] Q;
    logic       max_tick;
    logic       min_tick;

    int checks   = 0;
    int failures = 0;

    logic [3:0] model_q;
    logic       model_known;
    logic [3:0] exp_q[$];

    udl_counter #(.bits(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .up      (up),
        .load    (load),
        .D       (D),
        .Q       (Q),
        .max_tick(max_tick),
        .min_tick(min_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
        $fatal(1, "timeout");
    end

    // One edge: drive at negedge, check ticks, push expected Q, pop after edge.
    task automatic step(input logic rst_n_i, input logic ld_i, input logic en_i,
                        input logic up_i, input logic [3:0] d_i, input string tag);
        logic [3:0] got_exp;
        logic       exp_max;
        logic       exp_min;
        @(negedge clk);
        reset_n = rst_n_i;
        load    = ld_i;
        enable  = en_i;
        up      = up_i;
        D       = d_i;
        #1;
        if (model_known) begin
            exp_max = (model_q == 4'hF) && up_i && en_i && !ld_i;
            exp_min = (model_q == 4'h0) && !up_i && en_i && !ld_i;
            checks++;
            assert (max_tick === exp_max) else begin
                failures++;
                $error("FAIL %s max_tick observed=%b expected=%b", tag, max_tick, exp_max);
            end
            checks++;
            assert (min_tick === exp_min) else begin
                failures++;
                $error("FAIL %s min_tick observed=%b expected=%b", tag, min_tick, exp_min);
            end
        end
        if (!rst_n_i) begin
            model_q = 4'h0;
        end else if (ld_i) begin
            model_q = d_i;
        end else if (en_i) begin
            model_q = up_i ? model_q + 4'd1 : model_q - 4'd1;
        end
        model_known = model_known || !rst_n_i;
        exp_q.push_back(model_q);
        @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $error("FAIL %s scoreboard empty observed=%h expected=<entry>", tag, Q);
        end else begin
            got_exp = exp_q.pop_front();
            assert (Q === got_exp) else begin
                failures++;
                $error("FAIL %s Q observed=%h expected=%h", tag, Q, got_exp);
            end
        end
    endtask

    initial begin
        model_q     = 4'h0;
        model_known = 1'b0;
        reset_n = 1'b1; load = 1'b0; enable = 1'b0; up = 1'b1; D = 4'h0;

        step(1'b0, 1'b0, 1'b0, 1'b1, 4'hx, "reset");
        for (int i = 0; i < 15; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 4'hx, "count_up");
        step(1'b1, 1'b0, 1'b0, 1'b1, 4'hx, "hold15_a");
        step(1'b1, 1'b0, 1'b0, 1'b1, 4'hx, "hold15_b");
        step(1'b1, 1'b0, 1'b1, 1'b1, 4'hx, "wrap_up");
        step(1'b1, 1'b0, 1'b1, 1'b1, 4'hx, "up_to_1");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 4'hx, "count_down_wrap");

        step(1'b1, 1'b1, 1'b1, 1'b0, 4'd9, "load9");
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 4'hx, "down_from9");
        step(1'b1, 1'b1, 1'b1, 1'b0, 4'd7, "load7_a");
        step(1'b1, 1'b1, 1'b1, 1'b0, 4'd7, "load7_b");
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 4'hx, "down_from7");

        step(1'b1, 1'b1, 1'b1, 1'b1, 4'd11, "load11_a");
        step(1'b1, 1'b1, 1'b1, 1'b1, 4'd11, "load11_b");
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 4'hx, "up_from11");

        step(1'b1, 1'b1, 1'b1, 1'b0, 4'd4, "load4");
        step(1'b0, 1'b1, 1'b1, 1'b1, 4'd5, "reset_mid_load");
        step(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, "load0_down_no_tick");
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'hx, "hold0_no_tick");
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 4'hx, "resume_up");

        checks++;
        assert (exp_q.size() == 0) else begin
            failures++;
            $error("FAIL scoreboard_drain leftover=%0d expected=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/udl_counter.md
# udl_counter

Parameterized synchronous up/down counter with parallel load and count enable. General-purpose building block for timers, address generators and loop counters. It sits inside a single clock domain and presents its count directly on `Q`. Terminal-count flags support cascading and wrap detection.

## Interface
- `bits`, default 4: counter width in bits; legal range 1..32.
- `clk` input 1: sole clock; all state updates on the rising edge.
- `reset_n` input 1: reset, synchronous and active-low, sampled on the `clk` rising edge.
- `enable` input 1: count enable; when high and `load` is low, `Q` steps by one each cycle.
- `up` input 1: direction; 1 counts up, 0 counts down.
- `load` input 1: parallel load request; overrides counting and ignores `enable`.
- `D` input `bits`: parallel load value.
- `Q` output `bits`: current count, registered.
- `max_tick` output 1: combinational; high when `Q` is all ones, `up`=1, `enable`=1 and `load`=0. Means the next edge wraps to 0.
- `min_tick` output 1: combinational; high when `Q`=0, `up`=0, `enable`=1 and `load`=0. Means the next edge wraps to all ones.

## Operation
- Priority at each rising edge, highest first:
  1. `reset_n`=0: `Q`<=0.
  2. `load`=1: `Q`<=`D`.
  3. `enable`=1 and `up`=1: `Q`<=`Q`+1.
  4. `enable`=1 and `up`=0: `Q`<=`Q`-1.
  5. Otherwise `Q` holds.
- Arithmetic is modulo 2^`bits`.
  - Up from all ones wraps to 0.
  - Down from 0 wraps to all ones.
  - No saturation, no carry-out beyond the tick flags.
- `load` held high for N cycles keeps `Q`=`D` for those N cycles. Counting resumes on the first edge with `load`=0.
- Changing `up` takes effect on the next edge. No dead cycle, no extra latency.
- `D` is sampled only on edges where `load`=1 and reset is inactive. It may be X/unknown at other times.

## Timing
- Reset value: `Q`=0. `max_tick`/`min_tick` are then driven from inputs only.
- Before the first rising edge with `reset_n`=0, `Q` is undefined. Reset must be held low across at least one rising edge.
- Latency: one cycle from any control change to `Q`. Inputs are sampled at the rising edge and `Q` updates after it.
- Reset asserted mid-count or mid-load clears `Q` on that edge. The pending load is discarded.
- Simultaneous `load` and `enable`: load wins.
- Simultaneous reset and `load`: reset wins.
- Tick flags are combinational from `Q` and controls and glitch-free at the sampling edge. Use only synchronously.

## Structure
- A shared package holds the default width constant (4) and the priority-encoded operation enum: HOLD, LOAD, INC, DEC, CLEAR.
- A single module is the natural form. Use one next-state combinational block feeding one register.
- No sub-module is required. An optional `udl_counter_tick` helper may compute the flags.

## Test plan
- Reset then count up: `reset_n` low for one edge → `Q`=0. Then `enable`=1, `up`=1 → `Q` reads 1,2,…,15 on successive edges.
- Hold and wrap:
  - Drop `enable` when `Q`=15 → `Q` stays 15.
  - Re-enable with `up`=1 → `Q`=0, and `max_tick` was high on the cycle before.
- Count down and wrap: `enable`=1, `up`=0 from `Q`=1 → `Q` reads 0, 15, 14. `min_tick` is high while `Q`=0.
- Load priority during down-count:
  - `D`=9, `load`=1 for one edge → `Q`=9, then 8, 7, … on following edges.
  - At `Q`=2, `D`=7 with `load` held 2 edges → `Q`=7,7, then 6,5,4,3,2 over the next 5 edges.
- Load with direction change: `D`=11, `up`=1, `load`=1 for 2 edges → `Q`=11,11, then 12,13,14,15,0.
- Reset mid-operation: assert `reset_n`=0 while `load`=1 and `enable`=1 → `Q`=0 on that edge. Counting resumes from 0 after release.
